// File: rtl/adc_os_cal_seq_pkg.sv
// Shared types and defaults for the interleaved-ADC slicer offset calibration sequencer.
package adc_os_cal_seq_pkg;

  localparam int DEF_WAYS      = 8;
  localparam int DEF_BITS      = 9;
  localparam int DEF_TRIM_BITS = 8;
  localparam int DEF_SETTLE    = 4;
  localparam int DEF_ACC_LOG2  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    SETTLE_ST,
    ACC,
    DECIDE,
    NEXT,
    FIN
  } state_t;

  function automatic int unsigned mid_code(input int unsigned trim_bits);
    return 32'd1 << (trim_bits - 1);
  endfunction

  localparam int unsigned TRIM_MID = mid_code(DEF_TRIM_BITS);

endpackage

// File: rtl/adc_os_avg.sv
// Per-decision averager: sums 2^ACC_LOG2 accepted samples and compares the mean to mid-scale.
module adc_os_avg #(
  parameter int BITS     = 9,
  parameter int ACC_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clear,
  input  logic            en,
  input  logic            valid,
  input  logic [BITS-1:0] sample,
  output logic            last,
  output logic            above
);

  localparam int AW = BITS + ACC_LOG2;
  localparam logic [BITS-1:0] HALF = BITS'(1) << (BITS - 1);

  logic [AW-1:0]       acc;
  logic [ACC_LOG2-1:0] cnt;
  logic [BITS-1:0]     mean;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (en && valid) begin
      acc <= acc + AW'(sample);
      cnt <= cnt + ACC_LOG2'(1);
    end
  end

  // The final accepted sample is the one arriving while the counter is all ones.
  assign last  = en && valid && (cnt == '1);
  assign mean  = acc[AW-1:ACC_LOG2];
  assign above = mean > HALF;

endmodule

// File: rtl/adc_os_cal_seq.sv
// Successive-approximation trim search for the OSP/OSM slicer offsets of each interleaved way.
module adc_os_cal_seq
  import adc_os_cal_seq_pkg::*;
#(
  parameter int WAYS      = DEF_WAYS,
  parameter int BITS      = DEF_BITS,
  parameter int TRIM_BITS = DEF_TRIM_BITS,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int ACC_LOG2  = DEF_ACC_LOG2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      adc_valid,
  input  logic [WAYS*BITS-1:0]      adcout,
  output logic [WAYS*TRIM_BITS-1:0] osp,
  output logic [WAYS*TRIM_BITS-1:0] osm,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(WAYS)-1:0]   way,
  output state_t                    fsm_state
);

  localparam int WW = $clog2(WAYS);
  localparam int BW = $clog2(TRIM_BITS);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [TRIM_BITS-1:0] MID      = TRIM_BITS'(mid_code(TRIM_BITS));
  localparam logic [WW-1:0]        LAST_WAY = WW'(WAYS - 1);
  localparam logic [BW-1:0]        TOP_BIT  = BW'(TRIM_BITS - 1);
  localparam logic [SW-1:0]        SET_LAST = SW'(SETTLE - 1);

  state_t                state, state_n;
  logic [WW-1:0]         cur_way, way_inc;
  logic [BW-1:0]         bit_q;
  logic [SW-1:0]         settle_cnt;
  logic [TRIM_BITS-1:0]  code [WAYS];
  logic [BITS-1:0]       sample;
  logic                  avg_last, avg_above, run_abort;

  assign run_abort = abort && (state != IDLE);
  assign way_inc   = cur_way + WW'(1);
  assign sample    = adcout[int'(cur_way)*BITS +: BITS];

  adc_os_avg #(
    .BITS     (BITS),
    .ACC_LOG2 (ACC_LOG2)
  ) u_avg (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state == SETTLE_ST),
    .en     (state == ACC),
    .valid  (adc_valid),
    .sample (sample),
    .last   (avg_last),
    .above  (avg_above)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start && !abort) state_n = SET;
      SET:       state_n = SETTLE_ST;
      SETTLE_ST: if (settle_cnt == SET_LAST) state_n = ACC;
      ACC:       if (avg_last) state_n = DECIDE;
      DECIDE:    state_n = (bit_q == '0) ? NEXT : SET;
      NEXT:      state_n = (cur_way == LAST_WAY) ? FIN : SET;
      FIN:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    // Abort outranks every other transition once a run is in flight.
    if (run_abort) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_way    <= '0;
      bit_q      <= TOP_BIT;
      settle_cnt <= '0;
      for (int i = 0; i < WAYS; i++) code[i] <= MID;
    end else if (run_abort) begin
      code[cur_way] <= MID;
      cur_way       <= '0;
      bit_q         <= TOP_BIT;
      settle_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cur_way <= '0;
            bit_q   <= TOP_BIT;
            code[0] <= '0;
          end
        end
        SET: begin
          code[cur_way][bit_q] <= 1'b1;
          settle_cnt           <= '0;
        end
        SETTLE_ST: settle_cnt <= settle_cnt + SW'(1);
        DECIDE: begin
          if (avg_above) code[cur_way][bit_q] <= 1'b0;
          if (bit_q != '0) bit_q <= bit_q - BW'(1);
        end
        NEXT: begin
          if (cur_way != LAST_WAY) begin
            cur_way       <= way_inc;
            code[way_inc] <= '0;
            bit_q         <= TOP_BIT;
          end
        end
        FIN:     cur_way <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    osp = '0;
    for (int i = 0; i < WAYS; i++) osp[i*TRIM_BITS +: TRIM_BITS] = code[i];
  end

  assign osm       = ~osp;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign way       = cur_way;
  assign fsm_state = state;

endmodule

// File: tb/tb_adc_os_cal_seq.sv
// Bench for adc_os_cal_seq: ADC plant model, timeline/SAR reference model and a per-cycle compare.
module tb_adc_os_cal_seq;
  import adc_os_cal_seq_pkg::*;

  localparam int WAYS = 8;
  localparam int BITS = 9;
  localparam int TB   = 8;
  localparam int MAXK = 8192;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 adc_valid = 1'b0;
  logic [WAYS*BITS-1:0] adcout;
  logic [WAYS*TB-1:0]   osp, osm;
  logic                 busy, done;
  logic [2:0]           way;
  state_t               fsm_state;

  adc_os_cal_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .adc_valid (adc_valid),
    .adcout    (adcout),
    .osp       (osp),
    .osm       (osm),
    .busy      (busy),
    .done      (done),
    .way       (way),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC plant ----------------
  int         plant_mode = 0;
  logic [7:0] tgt [WAYS];

  always_comb begin
    adcout = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (plant_mode == 1) adcout[w*BITS +: BITS] = 9'd256;
      else adcout[w*BITS +: BITS] = 9'(256 + int'(osp[w*TB +: TB]) - int'(tgt[w]));
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] old_code [WAYS];
  logic [7:0] new_code [WAYS];
  int         tl_way [MAXK];
  bit         tl_acc [MAXK];
  bit         valid_pat [MAXK];
  int         done_cycle = 0;
  int         abort_at = 0;
  int         cur_k = 0;
  bit         chk_on = 1'b0;

  function automatic logic [7:0] sar_code(input int mode, input logic [7:0] t);
    logic [7:0] c;
    int mean;
    c = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      c[b] = 1'b1;
      mean = (mode == 1) ? 256 : (256 + int'(c) - int'(t));
      if (mean > 256) c[b] = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [63:0] pack(input logic [7:0] c [WAYS]);
    logic [63:0] v;
    for (int w = 0; w < WAYS; w++) v[w*8 +: 8] = c[w];
    return v;
  endfunction

  // Cycle k = interval after the k-th clock edge following the START-accepting edge.
  task automatic mark(inout int k, input int w, input bit acc);
    if (k >= MAXK - 2) begin
      $display("FAIL timeline_overflow: got %0d expected below %0d", k, MAXK);
      $fatal(1, "timeline overflow");
    end
    tl_way[k] = w;
    tl_acc[k] = acc;
    k++;
  endtask

  task automatic build_timeline();
    int k, cnt;
    k = 1;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < TB; b++) begin
        mark(k, w, 1'b0);                        // trial bit set
        for (int s = 0; s < 4; s++) mark(k, w, 1'b0);
        cnt = 0;
        while (cnt < 16) begin
          if (valid_pat[k]) cnt++;
          mark(k, w, 1'b1);
        end
        mark(k, w, 1'b0);                        // decision
      end
      mark(k, w, 1'b0);                          // way advance
    end
    tl_way[k] = WAYS - 1;
    tl_acc[k] = 1'b0;
    done_cycle = k;
  endtask

  // ---------------- per-cycle compare ----------------
  logic [63:0] cmp_e;
  int          cmp_w;

  always @(negedge clk) begin
    if (chk_on) begin
      if ((abort_at > 0 && cur_k > abort_at) || cur_k > done_cycle) begin
        check("idle_busy", busy, 0);
        check("idle_way", way, 0);
        check("idle_done", done, 0);
        check("idle_osp", osp, pack(new_code));
        check("idle_osm", osm, ~pack(new_code));
      end else begin
        cmp_w = tl_way[cur_k];
        for (int u = 0; u < WAYS; u++) begin
          if (cur_k == done_cycle || u < cmp_w) cmp_e[u*8 +: 8] = new_code[u];
          else if (u > cmp_w) cmp_e[u*8 +: 8] = old_code[u];
          else cmp_e[u*8 +: 8] = osp[u*8 +: 8];
        end
        check("run_busy", busy, 1);
        check("run_way", way, 64'(cmp_w));
        check("run_done", done, (cur_k == done_cycle) ? 1 : 0);
        check("run_osp", osp, cmp_e);
        check("run_osm", osm, ~cmp_e);
      end
    end
  end

  // ---------------- driver ----------------
  // vmode: 0 continuous valid, 1 one cycle in three, 2 random density
  task automatic run_cal(input int mode, input int vmode, input bit do_abort, input bit noise);
    int pct, acc_seen, last_k, stop_k;
    plant_mode = mode;
    pct = $urandom_range(40, 100);
    for (int k = 0; k < MAXK; k++) begin
      case (vmode)
        0:       valid_pat[k] = 1'b1;
        1:       valid_pat[k] = (k % 3 == 0);
        default: valid_pat[k] = ($urandom_range(1, 100) <= pct);
      endcase
    end
    build_timeline();
    abort_at = 0;
    if (do_abort) begin
      acc_seen = 0;
      for (int k = 1; k <= done_cycle && abort_at == 0; k++) begin
        if (tl_way[k] == 3 && tl_acc[k]) begin
          acc_seen++;
          if (acc_seen == 37) abort_at = k;
        end
      end
    end
    for (int u = 0; u < WAYS; u++) begin
      if (!do_abort) new_code[u] = sar_code(mode, tgt[u]);
      else if (u < 3) new_code[u] = sar_code(mode, tgt[u]);
      else if (u == 3) new_code[u] = 8'h80;
      else new_code[u] = old_code[u];
    end
    exp_q.push_back(pack(new_code));
    stop_k = do_abort ? abort_at : done_cycle;
    last_k = stop_k + 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_on = 1'b1;
    for (int k = 1; k <= last_k; k++) begin
      cur_k = k;
      adc_valid = valid_pat[k];
      abort = (k == abort_at);
      start = noise && (k <= stop_k) && ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    chk_on = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    adc_valid = 1'b0;
    check("final_osp", osp, exp_q.pop_front());
    for (int u = 0; u < WAYS; u++) old_code[u] = new_code[u];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_way", way, 0);
    check("reset_state_idle", (fsm_state == IDLE) ? 1 : 0, 1);
    check("reset_osp", osp, 64'h8080808080808080);
    check("reset_osm", osm, 64'h7F7F7F7F7F7F7F7F);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < WAYS; u++) old_code[u] = 8'h80;

    check("model_sar_5a", sar_code(0, 8'h5A), 8'h5A);
    check("model_sar_ff", sar_code(0, 8'hFF), 8'hFF);
    check("model_sar_flat256", sar_code(1, 8'h33), 8'hFF);

    tgt = '{8'h00, 8'h5A, 8'h80, 8'hFF, 8'h01, 8'h7F, 8'hC3, 8'h3C};
    run_cal(0, 0, 1'b0, 1'b1);
    check("sched_continuous", done_cycle, 1417);
    check("targets_osp", osp, 64'h3CC37F01FF805A00);
    check("targets_osm", osm, ~64'h3CC37F01FF805A00);

    run_cal(0, 1, 1'b0, 1'b0);
    check("sched_third_later", (done_cycle > 1417) ? 1 : 0, 1);
    check("third_osp", osp, 64'h3CC37F01FF805A00);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    check("start_abort_idle_busy2", busy, 0);
    check("start_abort_idle_osp", osp, 64'h3CC37F01FF805A00);

    for (int u = 0; u < WAYS; u++) tgt[u] = 8'($urandom_range(0, 255));
    run_cal(0, 2, 1'b1, 1'b1);

    run_cal(1, 2, 1'b0, 1'b1);
    check("flat256_osp", osp, 64'hFFFFFFFFFFFFFFFF);

    for (int u = 0; u < WAYS; u++) tgt[u] = 8'($urandom_range(0, 255));
    run_cal(0, 0, 1'b0, 1'b1);
    check("sched_continuous_rand", done_cycle, 1417);

    plant_mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    adc_valid = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_osp", osp, 64'h8080808080808080);
    check("async_reset_osm", osm, 64'h7F7F7F7F7F7F7F7F);
    check("async_reset_busy", busy, 0);
    check("async_reset_way", way, 0);
    check("async_reset_done", done, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    adc_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_os_cal_seq.md
ADC_OS_CAL_SEQ -- requirements
Module: adc_os_cal_seq

Interface
REQ-001 Parameter WAYS, default 8: number of interleaved sub-ADCs.
REQ-002 Parameter BITS, default 9: sub-ADC output width.
REQ-003 Parameter TRIM_BITS, default 8: width of the OSP/OSM trim code per way.
REQ-004 Parameter SETTLE, default 4: CLK cycles waited after each trim change.
REQ-005 Parameter ACC_LOG2, default 4: log2 of the number of samples averaged per decision.
REQ-006 CLK  in  1  block clock, the deserialized ADC clock domain.
REQ-007 RSTN  in  1  asynchronous active-low reset.
REQ-008 START  in  1  single-cycle request to begin a full calibration run.
REQ-009 ABORT  in  1  stop the run and return to idle.
REQ-010 ADC_VALID  in  1  ADCOUT holds a new sample set this cycle.
REQ-011 ADCOUT  in  WAYS*BITS  sub-ADC codes, way w at bits [w*BITS +: BITS], MSB highest.
REQ-012 OSP  out  WAYS*TRIM_BITS  positive slicer trim, way w at [w*TRIM_BITS +: TRIM_BITS].
REQ-013 OSM  out  WAYS*TRIM_BITS  negative slicer trim; always the bitwise inverse of OSP, per way.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 DONE  out  1  one-cycle pulse when a run completes without abort.
REQ-016 WAY  out  clog2(WAYS)  index of the way under calibration; 0 when idle.

Function
REQ-017 The block SHALL use the states IDLE, SET, SETTLE_ST, ACC, DECIDE, NEXT and FIN.
REQ-018 IDLE: START=1 with ABORT=0 SHALL select way 0 and trial bit TRIM_BITS-1, set that way's code to 0, then enter SET.
REQ-019 SET (1 cycle): the trial bit of the current way's code SHALL be set; then enter SETTLE_ST.
REQ-020 SETTLE_ST SHALL last exactly SETTLE cycles, ADC_VALID ignored; then enter ACC with the accumulator and sample counter cleared.
REQ-021 ACC SHALL add ADCOUT[WAY] into a BITS+ACC_LOG2-bit accumulator only on ADC_VALID cycles, and leave after 2^ACC_LOG2 accepted samples; it cannot overflow.
REQ-022 DECIDE (1 cycle): mean = accumulator >> ACC_LOG2; if mean > 2^(BITS-1), the trial bit SHALL be cleared, otherwise kept.
REQ-023 After DECIDE, if the trial bit was bit 0 the block SHALL enter NEXT; otherwise it moves the trial bit down by one and enters SET.
REQ-024 NEXT (1 cycle): if WAY = WAYS-1 enter FIN; otherwise increment WAY, clear the new way's code, reset the trial bit and enter SET.
REQ-025 FIN (1 cycle) SHALL pulse DONE, then enter IDLE; WAY returns to 0.
REQ-026 START while BUSY SHALL be ignored.
REQ-027 ABORT in any non-IDLE state SHALL have priority over every transition.
REQ-028 ABORT SHALL return the block to IDLE next cycle without a DONE pulse, setting the in-progress way's code to the midpoint 2^(TRIM_BITS-1); completed ways keep their codes.
REQ-029 START and ABORT together in IDLE SHALL be ignored.
REQ-030 Only the way under calibration SHALL change its OSP/OSM; the other ways hold their values.
REQ-031 With continuous ADC_VALID, each bit SHALL take 2+SETTLE+2^ACC_LOG2 cycles.
REQ-032 With default parameters and continuous ADC_VALID, DONE SHALL be high on the 1417th cycle after the START-accepting edge (8 ways x 177 cycles, plus FIN).

Reset
REQ-033 RSTN low SHALL force, asynchronously: state IDLE, every OSP code = 2^(TRIM_BITS-1) (0x80), OSM = 0x7F, BUSY=0, DONE=0, WAY=0, accumulator and counters = 0.
REQ-034 Reset deassertion SHALL take effect on the next CLK edge; reset mid-run discards all partial results.

Structure
REQ-035 A shared package SHALL hold the state enum, the midpoint-code constant and the default parameter values.
REQ-036 The per-decision averager (accumulator, sample counter and mean compare) SHALL be one sub-module, adc_os_avg; the FSM and trim registers stay in adc_os_cal_seq.

Verification
REQ-037 Per-way model ADCOUT = 256 + code - target with targets {0x00,0x5A,0x80,0xFF,0x01,0x7F,0xC3,0x3C} and continuous valid -> final OSP equals the targets, OSM equals their inverses, DONE on cycle 1417.
REQ-038 Same as REQ-037 with ADC_VALID high one cycle in three -> identical final codes, with DONE later than cycle 1417.
REQ-039 ABORT in way 3 during ACC -> IDLE next cycle, no DONE, ways 0-2 calibrated, way 3 = 0x80, ways 4-7 unchanged.
REQ-040 START pulsed while BUSY -> no restart and unchanged cycle count; START and ABORT together in IDLE -> BUSY stays 0.
REQ-041 RSTN asserted mid-run asynchronously -> all OSP = 0x80 and all OSM = 0x7F without a clock edge, BUSY=0.
REQ-042 Model mean exactly 256 at every trial -> final codes 0xFF (all bits kept, boundary of the strict > compare).
